// File: rtl/rx_fsm.sv
// Receive-side USB packet framer: hunts for SYNC in the de-stuffed bit stream,
// assembles LSB-first payload bytes and frames the packet on SE0.
module rx_fsm #(
    parameter logic [7:0] SYNC_PATTERN = 8'h01,
    parameter int         MAX_BYTES    = 64,
    parameter int         HUNT_MAX     = 32,
    localparam int        CNT_W        = $clog2(MAX_BYTES + 1),
    localparam int        HUNT_W       = $clog2(HUNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             rx_enable,
    input  logic             rx_bit,
    input  logic             rx_bit_valid,
    input  logic             rx_se0,
    input  logic             stuff_err,
    output logic [7:0]       rx_data,
    output logic             rx_data_valid,
    output logic             rx_active,
    output logic             rx_done,
    output logic             rx_error,
    output logic [CNT_W-1:0] rx_byte_count
);

    typedef enum logic [2:0] {
        RX_S_IDLE     = 3'd0,
        RX_S_HUNT     = 3'd1,
        RX_S_DATA     = 3'd2,
        RX_S_DONE     = 3'd3,
        RX_S_ERROR    = 3'd4,
        RX_S_WAIT_EOP = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]  BYTE_LIMIT = CNT_W'(MAX_BYTES);
    localparam logic [HUNT_W-1:0] HUNT_LIMIT = HUNT_W'(HUNT_MAX);

    state_t             state, state_next;
    logic [7:0]         sr, sr_next;
    logic [7:0]         sr_shift;
    logic [2:0]         bit_cnt, bit_cnt_next;
    logic [HUNT_W-1:0]  hunt_cnt, hunt_cnt_next;
    logic [CNT_W-1:0]   byte_cnt_next;
    logic [7:0]         data_next;
    logic               data_valid_next;

    // New bits enter at the top so the first bit of a byte ends up in sr[0].
    assign sr_shift = {rx_bit, sr[7:1]};

    always_comb begin
        state_next      = state;
        sr_next         = sr;
        bit_cnt_next    = bit_cnt;
        hunt_cnt_next   = hunt_cnt;
        byte_cnt_next   = rx_byte_count;
        data_next       = rx_data;
        data_valid_next = 1'b0;

        case (state)
            RX_S_IDLE: begin
                if (rx_enable && !rx_se0) begin
                    state_next    = RX_S_HUNT;
                    sr_next       = 8'h00;
                    hunt_cnt_next = '0;
                    byte_cnt_next = '0;
                end
            end
            RX_S_HUNT: begin
                if (!rx_enable) begin
                    state_next = RX_S_IDLE;
                end else if (stuff_err || rx_se0) begin
                    state_next = RX_S_ERROR;
                end else if (rx_bit_valid) begin
                    sr_next       = sr_shift;
                    hunt_cnt_next = hunt_cnt + 1'b1;
                    if (sr_shift == SYNC_PATTERN) begin
                        state_next   = RX_S_DATA;
                        bit_cnt_next = 3'd0;
                    end else if (hunt_cnt_next == HUNT_LIMIT) begin
                        state_next = RX_S_ERROR;
                    end
                end
            end
            RX_S_DATA: begin
                if (!rx_enable) begin
                    state_next = RX_S_IDLE;
                end else if (stuff_err) begin
                    state_next = RX_S_ERROR;
                end else if (rx_se0) begin
                    // EOP is only clean on a byte boundary.
                    state_next = (bit_cnt == 3'd0) ? RX_S_DONE : RX_S_ERROR;
                end else if (rx_bit_valid) begin
                    sr_next      = sr_shift;
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (rx_byte_count < BYTE_LIMIT) begin
                            data_next       = sr_shift;
                            data_valid_next = 1'b1;
                            byte_cnt_next   = rx_byte_count + 1'b1;
                        end else begin
                            state_next = RX_S_ERROR;
                        end
                    end
                end
            end
            RX_S_DONE: begin
                state_next = RX_S_IDLE;
            end
            RX_S_ERROR: begin
                state_next = (!rx_enable || rx_se0) ? RX_S_IDLE : RX_S_WAIT_EOP;
            end
            RX_S_WAIT_EOP: begin
                // Swallow the rest of a corrupt packet so it cannot fake a SYNC.
                if (!rx_enable || rx_se0) begin
                    state_next = RX_S_IDLE;
                end
            end
            default: begin
                state_next = RX_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state         <= RX_S_IDLE;
            sr            <= 8'h00;
            bit_cnt       <= 3'd0;
            hunt_cnt      <= '0;
            rx_byte_count <= '0;
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            rx_active     <= 1'b0;
            rx_done       <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            state         <= state_next;
            sr            <= sr_next;
            bit_cnt       <= bit_cnt_next;
            hunt_cnt      <= hunt_cnt_next;
            rx_byte_count <= byte_cnt_next;
            rx_data       <= data_next;
            rx_data_valid <= data_valid_next;
            // Status flags are registered copies of the next-state decode.
            rx_active     <= (state_next == RX_S_DATA);
            rx_done       <= (state_next == RX_S_DONE);
            rx_error      <= (state_next == RX_S_ERROR);
        end
    end

endmodule

// File: tb/tb_rx_fsm.sv
// Scoreboard bench for rx_fsm: a packet-level reference model predicts byte,
// done and error events; a monitor pops and compares them as the DUT emits them.
module tb_rx_fsm;

    localparam logic [7:0] SYNC = 8'h01;
    localparam int MAXB = 2;
    localparam int HMAX = 32;
    localparam int CW = $clog2(MAXB + 1);

    localparam int M_IDLE = 0, M_HUNT = 1, M_DATA = 2, M_DONE = 3, M_ERR = 4, M_WAIT = 5;
    localparam int EV_BYTE = 0, EV_DONE = 1, EV_ERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         stamp;
    } ev_t;

    logic          clk = 1'b0;
    logic          nRST, rx_enable, rx_bit, rx_bit_valid, rx_se0, stuff_err;
    logic [7:0]    rx_data;
    logic          rx_data_valid, rx_active, rx_done, rx_error;
    logic [CW-1:0] rx_byte_count;

    rx_fsm #(.SYNC_PATTERN(SYNC), .MAX_BYTES(MAXB), .HUNT_MAX(HMAX)) dut (
        .clk(clk), .nRST(nRST), .rx_enable(rx_enable), .rx_bit(rx_bit),
        .rx_bit_valid(rx_bit_valid), .rx_se0(rx_se0), .stuff_err(stuff_err),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_active(rx_active),
        .rx_done(rx_done), .rx_error(rx_error), .rx_byte_count(rx_byte_count)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;
    ev_t  sbq[$];
    int   n_valid = 0, n_done = 0, n_err = 0;
    int   b_valid, b_done, b_err;

    // Reference model state (packet-level view).
    int         mode = M_IDLE;
    bit         hq[$];
    bit         dq[$];
    int         nbits = 0, nbytes = 0;
    logic [7:0] last_byte = 8'h00;
    int         exp_active_n = 0, exp_count_n = 0, exp_data_n = 0;
    int         exp_active = 0, exp_count = 0, exp_data = 0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        exp_active <= exp_active_n;
        exp_count  <= exp_count_n;
        exp_data   <= exp_data_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind  = kind;
        e.data  = d;
        e.stamp = cyc + 1;
        sbq.push_back(e);
    endtask

    task automatic enter_err();
        mode = M_ERR;
        push_ev(EV_ERR, 8'h00);
    endtask

    task automatic model(input logic r, input logic en, input logic b, input logic v,
                         input logic s, input logic st);
        int val;
        if (!r) begin
            mode = M_IDLE; nbytes = 0; last_byte = 8'h00;
            hq.delete(); dq.delete();
        end else begin
            case (mode)
                M_IDLE: if (en && !s) begin
                    mode = M_HUNT; hq.delete(); nbits = 0; nbytes = 0;
                end
                M_HUNT: begin
                    if (!en) mode = M_IDLE;
                    else if (st || s) enter_err();
                    else if (v) begin
                        hq.push_back(b);
                        if (hq.size() > 8) void'(hq.pop_front());
                        nbits++;
                        // Window of the most recent bits, oldest in the lowest position.
                        val = 0;
                        for (int i = 0; i < hq.size(); i++)
                            val += int'(hq[i]) << (8 - hq.size() + i);
                        if (val == int'(SYNC)) begin
                            mode = M_DATA; dq.delete();
                        end else if (nbits == HMAX) enter_err();
                    end
                end
                M_DATA: begin
                    if (!en) mode = M_IDLE;
                    else if (st) enter_err();
                    else if (s) begin
                        if (dq.size() == 0) begin
                            mode = M_DONE; push_ev(EV_DONE, 8'h00);
                        end else enter_err();
                    end else if (v) begin
                        dq.push_back(b);
                        if (dq.size() == 8) begin
                            val = 0;
                            for (int i = 0; i < 8; i++) val += int'(dq[i]) << i;
                            dq.delete();
                            if (nbytes < MAXB) begin
                                nbytes++;
                                last_byte = val[7:0];
                                push_ev(EV_BYTE, val[7:0]);
                            end else enter_err();
                        end
                    end
                end
                M_DONE: mode = M_IDLE;
                M_ERR:  mode = (!en || s) ? M_IDLE : M_WAIT;
                M_WAIT: if (!en || s) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
        exp_active_n = (mode == M_DATA) ? 1 : 0;
        exp_count_n  = nbytes;
        exp_data_n   = int'(last_byte);
    endtask

    task automatic step(input logic r, input logic en, input logic b, input logic v,
                        input logic s, input logic st);
        nRST = r; rx_enable = en; rx_bit = b; rx_bit_valid = v; rx_se0 = s; stuff_err = st;
        model(r, en, b, v, s, st);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] val, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step(1, 1, 0, 0, 0, 0);
            step(1, 1, val[i], 1, 0, 0);
        end
    endtask

    task automatic start_pkt();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
    endtask

    task automatic eop();
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);
    endtask

    task automatic mark();
        b_valid = n_valid; b_done = n_done; b_err = n_err;
    endtask

    task automatic expect_obs(input string name, input int dv, input int dd, input int de);
        chk({name, "_valids"}, n_valid - b_valid, dv);
        chk({name, "_dones"}, n_done - b_done, dd);
        chk({name, "_errors"}, n_err - b_err, de);
    endtask

    // Monitor: compares every emitted pulse against the scoreboard head.
    always @(negedge clk) begin
        int  kind;
        ev_t e;
        if (armed) begin
            if (rx_data_valid) n_valid++;
            if (rx_done) n_done++;
            if (rx_error) n_err++;
            while (sbq.size() > 0 && sbq[0].stamp < cyc) begin
                e = sbq.pop_front();
                checks++; errors++;
                $display("FAIL missing_event: kind %0d due cycle %0d, none by cycle %0d",
                         e.kind, e.stamp, cyc);
            end
            if (rx_data_valid || rx_done || rx_error) begin
                chk("pulse_onehot", 32'(rx_data_valid) + 32'(rx_done) + 32'(rx_error), 1);
                kind = rx_data_valid ? EV_BYTE : (rx_done ? EV_DONE : EV_ERR);
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", kind, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("event_cycle", cyc, e.stamp);
                    if (kind == EV_BYTE) chk("event_data", rx_data, e.data);
                end
            end
            chk("rx_active", rx_active, exp_active);
            chk("rx_byte_count", rx_byte_count, exp_count);
            chk("rx_data", rx_data, exp_data);
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0);
        armed = 1'b1;
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_active", rx_active, 0);
        chk("reset_count", rx_byte_count, 0);
        chk("reset_done", rx_done, 0);
        chk("reset_error", rx_error, 0);
        step(1, 0, 0, 0, 0, 0);

        // Nominal packet
        mark(); start_pkt(); send_bits(SYNC, 8, 0);
        chk("sync_active", rx_active, 1);
        send_bits(32'hA5, 8, 0); eop();
        chk("nom_count", rx_byte_count, 1);
        chk("nom_data", rx_data, 8'hA5);
        expect_obs("nominal", 1, 1, 0);

        // Leading noise before SYNC
        mark(); start_pkt(); send_bits(32'b011, 3, 0); send_bits(SYNC, 8, 0);
        send_bits(32'h3C, 8, 0); send_bits(32'hFF, 8, 0); eop();
        chk("noise_count", rx_byte_count, 2);
        chk("noise_data", rx_data, 8'hFF);
        expect_obs("noise", 2, 1, 0);

        // Partial byte at EOP
        mark(); start_pkt(); send_bits(SYNC, 8, 0); send_bits(32'b1010, 4, 0); eop();
        chk("partial_count", rx_byte_count, 0);
        chk("partial_active", rx_active, 0);
        expect_obs("partial", 0, 0, 1);

        // Stuff error mid-packet, then a SYNC pattern inside the corrupt tail
        mark(); start_pkt(); send_bits(SYNC, 8, 0); send_bits(32'h55, 8, 0);
        send_bits(32'b101, 3, 0);
        step(1, 1, 1, 1, 0, 1);
        send_bits(32'hC3016, 20, 0); eop();
        chk("stuff_data", rx_data, 8'h55);
        expect_obs("stuff", 1, 0, 1);

        // Byte overflow at MAX_BYTES
        mark(); start_pkt(); send_bits(SYNC, 8, 0);
        send_bits(32'h11, 8, 0); send_bits(32'h22, 8, 0); send_bits(32'h33, 8, 0);
        chk("ovf_active", rx_active, 0);
        eop();
        chk("ovf_count", rx_byte_count, 2);
        chk("ovf_data", rx_data, 8'h22);
        expect_obs("overflow", 2, 0, 1);

        // Hunt timeout
        mark(); start_pkt(); send_bits(32'h0, 31, 0);
        chk("hunt31_error", rx_error, 0);
        send_bits(32'h0, 1, 0);
        chk("hunt32_error", rx_error, 1);
        eop();
        expect_obs("timeout", 0, 0, 1);

        // Reset mid-packet
        start_pkt(); send_bits(SYNC, 8, 0); send_bits(32'b10110, 5, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_valid", rx_data_valid, 0);
        chk("rst_active", rx_active, 0);
        chk("rst_count", rx_byte_count, 0);
        chk("rst_flags", {rx_done, rx_error}, 0);

        // Disable mid-packet, then a clean packet
        mark(); start_pkt(); send_bits(SYNC, 8, 0); send_bits(32'b01101, 5, 0);
        step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        chk("dis_active", rx_active, 0);
        expect_obs("disable", 0, 0, 0);
        mark(); start_pkt(); send_bits(SYNC, 8, 0); send_bits(32'h5A, 8, 0); eop();
        chk("after_dis_data", rx_data, 8'h5A);
        expect_obs("after_disable", 1, 1, 0);

        // Randomised framed packets with gaps and injected faults
        for (int p = 0; p < 30; p++) begin
            int sel;
            start_pkt();
            send_bits($urandom, $urandom_range(0, 5), 1);
            send_bits(SYNC, 8, 1);
            for (int k = $urandom_range(0, 3); k > 0; k--) send_bits($urandom_range(0, 255), 8, 1);
            sel = $urandom_range(0, 9);
            if (sel == 0) step(1, 1, 1'($urandom_range(0, 1)), 1, 0, 1);
            else if (sel == 1) step(1, 0, 0, 1, 0, 0);
            else if (sel == 2) send_bits($urandom, $urandom_range(1, 7), 0);
            eop();
        end

        // Unstructured random traffic, zero-biased bits so SYNC appears often
        for (int c = 0; c < 500; c++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 49) == 0));
        end

        for (int c = 0; c < 4; c++) step(1, 1, 0, 0, 1, 0);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
